sterownik_rampy_pwm: RTL and testbench
======================================

# sterownik_rampy_pwm

- Ramp controller and PWM generator for the motor drive stage.
- Takes the rpm setpoint from the switch-driven setpoint block, latched on that block's change pulse.
- Slews the applied duty toward the setpoint at a bounded rate and sequences direction reversals through zero speed.
- Produces a glitch-free PWM output and direction signal for the H-bridge.

## Interface
- KROK_TAKTY, 100000, clk cycles per 1-unit duty step (ramp rate)
- PWM_DZIELNIK, 10, clk cycles per PWM phase tick; PWM period = 100 * PWM_DZIELNIK cycles
- MAX_RPM, 95, ceiling applied to latched setpoint
- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high reset
- we_rpm  in  7  requested setpoint, unsigned, 0..100 (percent duty)
- sygnal_zmiany_rpm  in  1  one-cycle pulse: latch we_rpm
- kierunek_zad  in  1  requested direction (0 = forward, 1 = reverse)
- stop  in  1  level; while high, effective target is 0
- pwm  out  1  PWM drive
- akt_rpm  out  7  current applied duty
- kierunek  out  1  applied direction
- stan  out  3  FSM state code
- gotowe  out  1  akt_rpm equals effective target, direction matches request

## Operation
- Setpoint latch
  - On sygnal_zmiany_rpm, cel <= min(we_rpm, MAX_RPM).
  - No pulse: cel holds.
- Effective target cel_ef
  - 0 if stop = 1, or if kierunek_zad != kierunek.
  - Otherwise cel.
- Ramp timer
  - Counts 0..KROK_TAKTY-1 while akt_rpm != cel_ef.
  - Held at 0 while akt_rpm == cel_ef.
  - On reaching KROK_TAKTY-1: akt_rpm steps ±1 toward cel_ef and the timer returns to 0.
  - Step is exactly 1, so akt_rpm never overshoots and never leaves 0..MAX_RPM.
- Direction swap
  - In any cycle with akt_rpm == 0 and kierunek_zad != kierunek: kierunek <= kierunek_zad.
  - Never changes while akt_rpm > 0.
- FSM states (stan code), evaluated every cycle, priority top-down:
  - ZMIANA_KIER (4): kierunek_zad != kierunek
  - STOP (0): akt_rpm == 0 and cel_ef == 0
  - ROZPED (1): akt_rpm < cel_ef
  - HAMOW (3): akt_rpm > cel_ef
  - PRACA (2): akt_rpm == cel_ef > 0
- gotowe = 1 in STOP or PRACA, otherwise 0.
- PWM
  - Prescaler counts 0..PWM_DZIELNIK-1; each wrap advances faza 0..99, wrapping 99→0.
  - Duty register wyp <= akt_rpm only when faza wraps 99→0, so there are no mid-period duty changes.
  - pwm = (faza < wyp); wyp = 0 gives constant 0.
- Simultaneous events
  - Change pulse with stop: cel updates, stop still dominates cel_ef.
  - Change pulse in the same cycle as a ramp step: the step uses the new cel_ef.
  - stop released mid-ramp-down: ramp reverses toward cel without a timer reset.
- Reset, also mid-operation, all synchronous:
  - cel = 0, akt_rpm = 0, kierunek = 0, wyp = 0.
  - Timer, prescaler and faza = 0.
  - pwm = 0, stan = STOP, gotowe = 1.

## Timing
- Registered outputs change on posedge clk only. pwm is combinational from registered faza and wyp.
- Pulse to first step: cel updates at edge N. The timer starts counting at edge N+1. akt_rpm first changes KROK_TAKTY cycles after the pulse.
- Full ramp 0→X: X * KROK_TAKTY cycles.
- Reversal at speed X toward setpoint Y: X * KROK_TAKTY cycles down, 1 cycle at 0 for the kierunek swap, then Y * KROK_TAKTY cycles up.
- Duty latency: a new akt_rpm reaches pwm at the next period boundary, up to 100 * PWM_DZIELNIK cycles later.

## Test plan
All scenarios use KROK_TAKTY=4, PWM_DZIELNIK=1.

- Reset, then pulse with we_rpm=20
  - stan=ROZPED.
  - akt_rpm increments every 4 cycles and reaches 20 after 80 cycles.
  - Then stan=PRACA, gotowe=1, pwm high for exactly 20 of every 100 cycles.
- Pulse we_rpm=100
  - cel clamps to 95; akt_rpm settles at 95, never higher.
- At akt_rpm=30, toggle kierunek_zad
  - stan=ZMIANA_KIER; kierunek holds while ramping down to 0.
  - kierunek flips in the cycle akt_rpm==0, then ramps back to 30 (total 240 cycles + 1).
- At akt_rpm=40, assert stop for 60 cycles then release
  - akt_rpm falls to 25, then rises to 40 without discontinuity.
- Change akt_rpm mid PWM period (faza=50)
  - pwm width in the current period is unchanged; the new width applies from the next faza=0.
- Assert rst at akt_rpm=50 in ROZPED
  - Next cycle all outputs are at reset values, pwm=0.
  - No ramp resumes until a new pulse.

Source files
------------

// File: rtl/sterownik_rampy_pwm.sv
// Ramp controller and PWM generator for the motor H-bridge: slews the applied duty toward
// a latched setpoint at a bounded rate, reverses direction only at zero speed.
module sterownik_rampy_pwm #(
  parameter int KROK_TAKTY   = 100000,
  parameter int PWM_DZIELNIK = 10,
  parameter int MAX_RPM      = 95
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] we_rpm,
  input  logic       sygnal_zmiany_rpm,
  input  logic       kierunek_zad,
  input  logic       stop,
  output logic       pwm,
  output logic [6:0] akt_rpm,
  output logic       kierunek,
  output logic [2:0] stan,
  output logic       gotowe
);

  localparam int TW = (KROK_TAKTY > 1) ? $clog2(KROK_TAKTY) : 1;
  localparam int PW = (PWM_DZIELNIK > 1) ? $clog2(PWM_DZIELNIK) : 1;

  typedef enum logic [2:0] {
    ST_STOP   = 3'd0,
    ST_ROZPED = 3'd1,
    ST_PRACA  = 3'd2,
    ST_HAMOW  = 3'd3,
    ST_ZMIANA = 3'd4
  } stan_t;

  function automatic logic [6:0] nasyc_rpm(input logic [6:0] v);
    if (v > 7'(MAX_RPM)) return 7'(MAX_RPM);
    return v;
  endfunction

  function automatic stan_t klasyfikuj(input logic [6:0] akt, input logic [6:0] cel_ef,
                                       input logic zmiana);
    if (zmiana)                          return ST_ZMIANA;
    if (akt == 7'd0 && cel_ef == 7'd0)   return ST_STOP;
    if (akt < cel_ef)                    return ST_ROZPED;
    if (akt > cel_ef)                    return ST_HAMOW;
    return ST_PRACA;
  endfunction

  logic [6:0]    cel_q, cel_d;
  logic [6:0]    akt_q, akt_d;
  logic          kier_q, kier_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    faza_q, faza_d;
  logic [6:0]    wyp_q, wyp_d;
  stan_t         stan_q, stan_d;
  logic          gotowe_q, gotowe_d;

  logic          zmiana, zmiana_nast;
  logic [6:0]    cel_ef, cel_ef_nowy, cel_ef_nast;

  always_comb begin
    cel_d = sygnal_zmiany_rpm ? nasyc_rpm(we_rpm) : cel_q;

    zmiana      = (kierunek_zad != kier_q);
    cel_ef      = (stop || zmiana) ? 7'd0 : cel_q;
    // The step direction follows a setpoint latched in the same cycle.
    cel_ef_nowy = (stop || zmiana) ? 7'd0 : cel_d;

    timer_d = timer_q;
    akt_d   = akt_q;
    if (akt_q == cel_ef) begin
      timer_d = '0;
    end else if (timer_q == TW'(KROK_TAKTY - 1)) begin
      timer_d = '0;
      if (akt_q < cel_ef_nowy)      akt_d = akt_q + 7'd1;
      else if (akt_q > cel_ef_nowy) akt_d = akt_q - 7'd1;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    kier_d = (akt_q == 7'd0 && zmiana) ? kierunek_zad : kier_q;

    // Duty is only reloaded at the period boundary so a period is never cut short.
    presc_d = presc_q + PW'(1);
    faza_d  = faza_q;
    wyp_d   = wyp_q;
    if (presc_q == PW'(PWM_DZIELNIK - 1)) begin
      presc_d = '0;
      if (faza_q == 7'd99) begin
        faza_d = 7'd0;
        wyp_d  = akt_q;
      end else begin
        faza_d = faza_q + 7'd1;
      end
    end

    zmiana_nast = (kierunek_zad != kier_d);
    cel_ef_nast = (stop || zmiana_nast) ? 7'd0 : cel_d;
    stan_d      = klasyfikuj(akt_d, cel_ef_nast, zmiana_nast);
    gotowe_d    = (stan_d == ST_STOP) || (stan_d == ST_PRACA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cel_q    <= '0;
      akt_q    <= '0;
      kier_q   <= 1'b0;
      timer_q  <= '0;
      presc_q  <= '0;
      faza_q   <= '0;
      wyp_q    <= '0;
      stan_q   <= ST_STOP;
      gotowe_q <= 1'b1;
    end else begin
      cel_q    <= cel_d;
      akt_q    <= akt_d;
      kier_q   <= kier_d;
      timer_q  <= timer_d;
      presc_q  <= presc_d;
      faza_q   <= faza_d;
      wyp_q    <= wyp_d;
      stan_q   <= stan_d;
      gotowe_q <= gotowe_d;
    end
  end

  assign pwm      = (faza_q < wyp_q);
  assign akt_rpm  = akt_q;
  assign kierunek = kier_q;
  assign stan     = stan_q;
  assign gotowe   = gotowe_q;

endmodule

// File: tb/tb_sterownik_rampy_pwm.sv
// Directed bench for sterownik_rampy_pwm: expectations are queued with their cycle number
// and a monitor process compares them as the design reaches that cycle.
module tb_sterownik_rampy_pwm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] we_rpm = 7'd0;
  logic       sygnal_zmiany_rpm = 1'b0;
  logic       kierunek_zad = 1'b0;
  logic       stop = 1'b0;
  logic       pwm;
  logic [6:0] akt_rpm;
  logic       kierunek;
  logic [2:0] stan;
  logic       gotowe;

  sterownik_rampy_pwm #(.KROK_TAKTY(4), .PWM_DZIELNIK(1), .MAX_RPM(95)) dut (
    .clk(clk), .rst(rst), .we_rpm(we_rpm), .sygnal_zmiany_rpm(sygnal_zmiany_rpm),
    .kierunek_zad(kierunek_zad), .stop(stop), .pwm(pwm), .akt_rpm(akt_rpm),
    .kierunek(kierunek), .stan(stan), .gotowe(gotowe)
  );

  always #5 clk = ~clk;

  localparam int S_AKT = 0, S_KIER = 1, S_STAN = 2, S_GOT = 3, S_PWM = 4, S_WIN = 5;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;
  bit   hist[100];
  int   win_sum = 0;
  int   hidx = 0;

  task automatic chk(input int t, input int sig, input int val, input string nm);
    exp_t e;
    e.cyc = t; e.sig = sig; e.val = val; e.nm = nm;
    sb.push_back(e);
  endtask

  function automatic int actual(input int sig);
    case (sig)
      S_AKT:   return int'(akt_rpm);
      S_KIER:  return int'(kierunek);
      S_STAN:  return int'(stan);
      S_GOT:   return int'(gotowe);
      S_PWM:   return int'(pwm);
      default: return win_sum;
    endcase
  endfunction

  // Monitor: sample 1 time unit after each rising edge
  initial begin
    for (int i = 0; i < 100; i++) hist[i] = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      win_sum = win_sum - int'(hist[hidx]) + int'(pwm);
      hist[hidx] = pwm;
      hidx = (hidx + 1) % 100;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          n_run++;
          if (actual(sb[i].sig) != sb[i].val) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d",
                     sb[i].nm, cyc, actual(sb[i].sig), sb[i].val);
          end
          sb.delete(i);
        end else if (sb[i].cyc < cyc) begin
          n_run++;
          n_fail++;
          $display("FAIL %s: check for cyc %0d never reached (now %0d)", sb[i].nm, sb[i].cyc, cyc);
          sb.delete(i);
        end
      end
    end
  end

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse(input logic [6:0] v);
    we_rpm = v;
    sygnal_zmiany_rpm = 1'b1;
    @(negedge clk);
    sygnal_zmiany_rpm = 1'b0;
  endtask

  initial begin
    int r;
    // reset state while rst is held
    chk(2, S_AKT, 0, "rst_akt");
    chk(2, S_STAN, 0, "rst_stan");
    chk(2, S_GOT, 1, "rst_gotowe");
    chk(2, S_PWM, 0, "rst_pwm");
    chk(2, S_KIER, 0, "rst_kier");
    goto(3);
    r = 3;
    rst = 1'b0;

    // ramp 0 -> 20
    chk(r + 1, S_STAN, 1, "s1_rozped");
    chk(r + 1, S_GOT, 0, "s1_gotowe0");
    chk(r + 4, S_AKT, 0, "s1_akt_before_step");
    chk(r + 5, S_AKT, 1, "s1_first_step");
    chk(r + 80, S_AKT, 19, "s1_akt19");
    chk(r + 81, S_AKT, 20, "s1_akt20");
    chk(r + 81, S_STAN, 2, "s1_praca");
    chk(r + 81, S_GOT, 1, "s1_gotowe1");
    chk(r + 99, S_WIN, 0, "s1_period0_width");
    chk(r + 119, S_PWM, 1, "s1_pwm_faza19");
    chk(r + 120, S_PWM, 0, "s1_pwm_faza20");
    chk(r + 199, S_WIN, 20, "s1_period_width20");
    pulse(7'd20);

    // ramp 20 -> 30
    goto(r + 200);
    chk(r + 241, S_AKT, 30, "sa_akt30");
    chk(r + 241, S_STAN, 2, "sa_praca");
    pulse(7'd30);

    // direction reversal at 30
    goto(r + 250);
    chk(r + 251, S_STAN, 4, "s3_zmiana");
    chk(r + 251, S_KIER, 0, "s3_kier_hold");
    chk(r + 251, S_GOT, 0, "s3_gotowe0");
    chk(r + 369, S_AKT, 1, "s3_akt1");
    chk(r + 369, S_KIER, 0, "s3_kier_hold_at1");
    chk(r + 370, S_AKT, 0, "s3_akt0");
    chk(r + 370, S_KIER, 0, "s3_kier_hold_at0");
    chk(r + 370, S_STAN, 4, "s3_zmiana_at0");
    chk(r + 371, S_KIER, 1, "s3_kier_swap");
    chk(r + 371, S_AKT, 0, "s3_akt0_swap");
    chk(r + 371, S_STAN, 1, "s3_rozped_after");
    chk(r + 375, S_AKT, 1, "s3_first_up");
    chk(r + 490, S_AKT, 29, "s3_akt29");
    chk(r + 491, S_AKT, 30, "s3_back30");
    chk(r + 491, S_STAN, 2, "s3_praca");
    kierunek_zad = 1'b1;

    // ramp 30 -> 40
    goto(r + 500);
    chk(r + 541, S_AKT, 40, "sb_akt40");
    pulse(7'd40);

    // stop pulse while at 40, release mid-step
    goto(r + 550);
    chk(r + 554, S_AKT, 39, "s4_down_first");
    chk(r + 609, S_AKT, 26, "s4_akt26");
    chk(r + 610, S_AKT, 25, "s4_akt25");
    chk(r + 610, S_STAN, 3, "s4_hamow");
    chk(r + 613, S_AKT, 25, "s4_min_hold");
    chk(r + 613, S_STAN, 1, "s4_rozped");
    chk(r + 614, S_AKT, 26, "s4_up_no_timer_reset");
    chk(r + 670, S_AKT, 40, "s4_back40");
    chk(r + 670, S_STAN, 2, "s4_praca");
    stop = 1'b1;
    goto(r + 612);
    stop = 1'b0;

    // clamp 100 -> 95, plus duty change inside a PWM period
    goto(r + 700);
    chk(r + 701, S_STAN, 1, "s2_rozped");
    chk(r + 701, S_GOT, 0, "s2_gotowe0");
    chk(r + 920, S_AKT, 94, "s2_akt94");
    chk(r + 921, S_AKT, 95, "s2_akt95");
    chk(r + 921, S_STAN, 2, "s2_praca");
    chk(r + 921, S_GOT, 1, "s2_gotowe1");
    chk(r + 950, S_PWM, 1, "s5_pwm_faza50");
    chk(r + 960, S_AKT, 95, "s2_no_overshoot");
    chk(r + 988, S_PWM, 1, "s5_pwm_faza88");
    chk(r + 989, S_PWM, 0, "s5_pwm_faza89_old_width");
    chk(r + 999, S_WIN, 89, "s5_period_width_held");
    chk(r + 1094, S_PWM, 1, "s5_pwm_faza94");
    chk(r + 1095, S_PWM, 0, "s5_pwm_faza95");
    chk(r + 1099, S_WIN, 95, "s5_period_width_new");
    pulse(7'd100);

    // down to 45, then up toward 60 and reset at 50
    goto(r + 1100);
    chk(r + 1301, S_AKT, 45, "s6_akt45");
    pulse(7'd45);
    goto(r + 1310);
    chk(r + 1331, S_AKT, 50, "s6_akt50");
    chk(r + 1331, S_STAN, 1, "s6_rozped");
    chk(r + 1331, S_KIER, 1, "s6_kier1");
    chk(r + 1333, S_AKT, 0, "s6_rst_akt");
    chk(r + 1333, S_STAN, 0, "s6_rst_stan");
    chk(r + 1333, S_GOT, 1, "s6_rst_gotowe");
    chk(r + 1333, S_PWM, 0, "s6_rst_pwm");
    chk(r + 1333, S_KIER, 0, "s6_rst_kier");
    chk(r + 1400, S_AKT, 0, "s6_no_resume_akt");
    chk(r + 1400, S_STAN, 0, "s6_no_resume_stan");
    chk(r + 1400, S_PWM, 0, "s6_no_resume_pwm");
    pulse(7'd60);
    goto(r + 1332);
    rst = 1'b1;
    kierunek_zad = 1'b0;
    goto(r + 1335);
    rst = 1'b0;

    goto(r + 1405);
    while (sb.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL %s: pending check for cyc %0d not performed", sb[0].nm, sb[0].cyc);
      sb.delete(0);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_run++;
    n_fail++;
    $display("FAIL timeout: cyc %0d reached, expected end near 1408", cyc);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
